// File: rtl/hamming_tx_sched.sv
// hamming_tx_sched: two-requester round-robin front end that frames 11-bit words for a serial Hamming encoder and collects its 16-bit codeword
module hamming_tx_sched #(
  parameter int DATA_W  = 11,
  parameter int CODE_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              enc_start,
  output logic              enc_din,
  input  logic              enc_dout,
  input  logic              enc_dout_valid,
  output logic [CODE_W-1:0] cw_data,
  output logic              cw_src,
  output logic              cw_valid,
  output logic              err_timeout,
  output logic              busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
  state_t state, state_n;
  logic last_grant;
  logic [DATA_W-1:0] data;
  logic [3:0] s;
  logic [4:0] cap_cnt;
  logic [TW-1:0] tcnt;
  logic [CODE_W-1:0] frame;
  logic grant0, grant1, cap, full_n, timeout;
  always_comb begin
    frame = {data[10:4], 1'b0, data[3:1], 1'b0, data[0], 3'b000};
    grant0 = state == IDLE && req0_valid && (!req1_valid || last_grant);
    grant1 = state == IDLE && req1_valid && (!req0_valid || !last_grant);
    cap = (state == SEND || state == WAIT) && enc_dout_valid && !cap_cnt[4];
    full_n = cap_cnt[4] || (cap && cap_cnt[3:0] == 4'hF);
    timeout = state == WAIT && !full_n && tcnt == TW'(TIMEOUT - 1);
    state_n = state == IDLE ? ((grant0 || grant1) ? SEND : IDLE) :
              state == SEND ? (s == 4'hF ? (full_n ? DONE : WAIT) : SEND) :
              state == WAIT ? (full_n ? DONE : timeout ? IDLE : WAIT) : IDLE;
    req0_ready = grant0;
    req1_ready = grant1;
    enc_start = state == SEND && s == 4'h0;
    enc_din = state == SEND && frame[s];
    cw_valid = state == DONE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      cw_src <= 1'b0;
      data <= '0;
      s <= '0;
      cap_cnt <= '0;
      tcnt <= '0;
      cw_data <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_n;
      err_timeout <= timeout;
      tcnt <= state == WAIT ? tcnt + 1'b1 : '0;
      if (grant0 || grant1) begin
        data <= grant1 ? req1_data : req0_data;
        cw_src <= grant1;
        last_grant <= grant1;
        s <= '0;
        cap_cnt <= '0;
      end
      if (state == SEND) s <= s + 1'b1;
      if (cap) begin
        cw_data[cap_cnt[3:0]] <= enc_dout;
        cap_cnt <= cap_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hamming_tx_sched.sv
// tb_hamming_tx_sched: directed self-checking bench for hamming_tx_sched
module tb_hamming_tx_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [10:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, enc_start, enc_din, cw_src, cw_valid, err_timeout, busy;
  logic enc_dout = 1'b0, enc_dout_valid = 1'b0;
  logic [15:0] cw_data;
  logic [15:0] exp2 = 16'hFEE8;
  int checks = 0, failures = 0;
  bit echo = 0;
  int budget = 0, scnt = 0;
  bit f1 = 0, f2 = 0, b1 = 0, b2 = 0;
  always #5 clk = ~clk;
  hamming_tx_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .enc_start(enc_start), .enc_din(enc_din), .enc_dout(enc_dout), .enc_dout_valid(enc_dout_valid),
    .cw_data(cw_data), .cw_src(cw_src), .cw_valid(cw_valid), .err_timeout(err_timeout), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    bit flag;
    @(posedge clk);
    #1;
    if (rst) begin
      scnt = 0; f1 = 0; f2 = 0;
    end else begin
      flag = enc_start || scnt > 0;
      scnt = enc_start ? 15 : (scnt > 0 ? scnt - 1 : 0);
      if (echo) begin
        enc_dout_valid = f2 && budget > 0;
        enc_dout = b2;
        if (enc_dout_valid) budget--;
      end
      f2 = f1; b2 = b1; f1 = flag; b1 = enc_din;
    end
    #1;
  endtask
  initial begin
    int n, lastg;
    bit prev, found, any_cw, any_err;
    repeat (2) tick;
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_cw_valid", cw_valid, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_cw_data", cw_data, 0);
    chk("rst_cw_src", cw_src, 0);
    chk("rst_start", enc_start, 0);
    chk("rst_din", enc_din, 0);
    req0_valid = 1; req0_data = 11'h001;
    #1;
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    for (int k = 0; k < 16; k++) begin
      tick;
      if (k == 0) req0_valid = 0;
      chk("t1_start", enc_start, k == 0);
      chk("t1_din", enc_din, k == 3);
      if (k == 0) chk("t1_busy", busy, 1);
    end
    tick;
    chk("t1_wait_din", enc_din, 0);
    chk("t1_wait_start", enc_start, 0);
    chk("t1_wait_busy", busy, 1);
    rst = 1; tick; rst = 0;
    echo = 1; budget = 16;
    req1_valid = 1; req1_data = 11'h7FF;
    #1;
    chk("t2_ready1", req1_ready, 1);
    chk("t2_ready0", req0_ready, 0);
    for (int k = 0; k < 16; k++) begin
      tick;
      if (k == 0) req1_valid = 0;
      chk("t2_din", enc_din, exp2[k]);
    end
    tick;
    chk("t2_cwv_t17", cw_valid, 0);
    tick;
    chk("t2_cwv_t18", cw_valid, 0);
    tick;
    chk("t2_cwv_t19", cw_valid, 1);
    chk("t2_cw_src", cw_src, 1);
    chk("t2_cw_data", cw_data, 16'hFEE8);
    tick;
    chk("t2_cwv_off", cw_valid, 0);
    chk("t2_busy_off", busy, 0);
    budget = 1000;
    req0_valid = 1; req1_valid = 1; req0_data = 11'h123; req1_data = 11'h456;
    n = 0; lastg = 0; prev = 0;
    for (int c = 0; c < 200 && n < 4; c++) begin
      #1;
      chk("t3_both_ready", req0_ready && req1_ready, 0);
      chk("t3_ready_busy", (req0_ready || req1_ready) && busy, 0);
      if (req0_ready || req1_ready) begin
        chk("t3_order", req1_ready, n % 2);
        chk("t3_pulse", prev, 0);
        if (n > 0) chk("t3_period", c - lastg, 20);
        lastg = c; n++;
      end
      prev = req0_ready || req1_ready;
      tick;
    end
    chk("t3_grants", n, 4);
    req0_valid = 0; req1_valid = 0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (cw_valid) found = 1; else tick;
    end
    chk("t3_cw_found", found, 1);
    chk("t3_cw_src", cw_src, 1);
    chk("t3_cw_data", cw_data, 16'h8A60);
    tick;
    budget = 10;
    req0_valid = 1; req0_data = 11'h555;
    #1;
    chk("t4_ready0", req0_ready, 1);
    any_cw = 0; any_err = 0;
    for (int k = 1; k <= 80; k++) begin
      tick;
      if (k == 1) req0_valid = 0;
      any_cw |= cw_valid;
      any_err |= err_timeout;
    end
    chk("t4_err_early", any_err, 0);
    chk("t4_busy_t80", busy, 1);
    tick;
    chk("t4_err_t81", err_timeout, 1);
    chk("t4_busy_t81", busy, 0);
    chk("t4_cwv_t81", cw_valid, 0);
    tick;
    chk("t4_err_t82", err_timeout, 0);
    chk("t4_busy_t82", busy, 0);
    chk("t4_no_cw", any_cw | cw_valid, 0);
    echo = 0; enc_dout_valid = 0;
    req0_valid = 1; req0_data = 11'h7FF;
    #1;
    chk("t5_ready0", req0_ready, 1);
    for (int k = 0; k < 8; k++) begin
      tick;
      if (k == 0) req0_valid = 0;
    end
    chk("t5_slot7_din", enc_din, 1);
    rst = 1; tick; rst = 0;
    chk("t5_busy", busy, 0);
    chk("t5_start", enc_start, 0);
    chk("t5_din", enc_din, 0);
    chk("t5_cw_valid", cw_valid, 0);
    chk("t5_err", err_timeout, 0);
    chk("t5_cw_data", cw_data, 0);
    chk("t5_cw_src", cw_src, 0);
    echo = 1; budget = 15;
    req0_valid = 1; req1_valid = 1; req0_data = 11'h001; req1_data = 11'h2AA;
    #1;
    chk("t5_tie_ready0", req0_ready, 1);
    chk("t5_tie_ready1", req1_ready, 0);
    for (int k = 1; k <= 80; k++) begin
      tick;
      if (k == 1) begin req0_valid = 0; req1_valid = 0; end
    end
    echo = 0; enc_dout_valid = 1; enc_dout = 1;
    chk("t6_err_t80", err_timeout, 0);
    chk("t6_busy_t80", busy, 1);
    chk("t6_cwv_t80", cw_valid, 0);
    tick;
    enc_dout_valid = 0; enc_dout = 0;
    chk("t6_cwv_t81", cw_valid, 1);
    chk("t6_err_t81", err_timeout, 0);
    chk("t6_cw_src", cw_src, 0);
    chk("t6_cw_data", cw_data, 16'h8008);
    tick;
    chk("t6_cwv_t82", cw_valid, 0);
    chk("t6_err_t82", err_timeout, 0);
    chk("t6_busy_t82", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
